// File: rtl/qpsk_symbol_detector.sv
// qpsk_symbol_detector: coherent QPSK back-end. Correlates 16-sample carrier
// symbols against cos/sin references and emits I/Q sums plus a hard decision.
// Optional erasure flag (and ERASE_THRESH parameter) with QPSK_DET_ERASE_EN.
module qpsk_symbol_detector
`ifdef QPSK_DET_ERASE_EN
  #(parameter int ERASE_THRESH = 20000)
`endif
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [9:0]  sample_in,
  input  logic               sample_valid,
  input  logic               sync,
  output logic [1:0]         symbol_out,
  output logic               symbol_valid,
  output logic signed [21:0] i_corr,
  output logic signed [21:0] q_corr
`ifdef QPSK_DET_ERASE_EN
  ,
  output logic               erasure
`endif
);

  // cos(2*pi*k/16) scaled by 127; sin[k] is read as cos[k-4].
  function automatic logic signed [7:0] cos_rom(input logic [3:0] k);
    logic signed [7:0] v;
    case (k)
      4'd0:    v = 8'sd127;
      4'd1:    v = 8'sd117;
      4'd2:    v = 8'sd90;
      4'd3:    v = 8'sd49;
      4'd4:    v = 8'sd0;
      4'd5:    v = -8'sd49;
      4'd6:    v = -8'sd90;
      4'd7:    v = -8'sd117;
      4'd8:    v = -8'sd127;
      4'd9:    v = -8'sd117;
      4'd10:   v = -8'sd90;
      4'd11:   v = -8'sd49;
      4'd12:   v = 8'sd0;
      4'd13:   v = 8'sd49;
      4'd14:   v = 8'sd90;
      default: v = 8'sd117;
    endcase
    return v;
  endfunction

  logic [3:0]         phase_q, phase_d, idx;
  logic signed [17:0] p_i_q, p_i_d, p_q_q, p_q_d;
  logic signed [17:0] smp_ext, cos_ext, sin_ext;
  logic               s1_valid_q, s1_valid_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic signed [21:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [21:0] i_corr_q, i_corr_d, q_corr_q, q_corr_d;
  logic [1:0]         symbol_out_q, symbol_out_d;
  logic               symbol_valid_q, symbol_valid_d;

  // Phase tracking and stage 1: reference multiply of the accepted sample.
  always_comb begin
    idx        = sync ? 4'd0 : phase_q;
    phase_d    = phase_q;
    smp_ext    = 18'(sample_in);
    cos_ext    = 18'(cos_rom(idx));
    sin_ext    = 18'(cos_rom(idx - 4'd4));
    p_i_d      = p_i_q;
    p_q_d      = p_q_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s1_valid_d = sample_valid;
    if (sample_valid) begin
      phase_d    = idx + 4'd1;
      p_i_d      = smp_ext * cos_ext;
      p_q_d      = smp_ext * sin_ext;
      s1_first_d = (idx == 4'd0);
      s1_last_d  = (idx == 4'd15);
    end
  end

  // Stage 2: accumulate; the index-0 product restarts the sum, so a sync
  // silently drops any partial symbol.
  always_comb begin
    acc_i_d        = acc_i_q;
    acc_q_d        = acc_q_q;
    if (s1_valid_q) begin
      acc_i_d = (s1_first_q ? 22'sd0 : acc_i_q) + 22'(p_i_q);
      acc_q_d = (s1_first_q ? 22'sd0 : acc_q_q) + 22'(p_q_q);
    end
    symbol_valid_d = s1_valid_q && s1_last_q;
    i_corr_d       = symbol_valid_d ? acc_i_d : i_corr_q;
    q_corr_d       = symbol_valid_d ? acc_q_d : q_corr_q;
    symbol_out_d   = symbol_valid_d ? {~acc_i_d[21], ~acc_q_d[21]} : symbol_out_q;
  end

  // All pipeline and output state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q        <= 4'd0;
      p_i_q          <= '0;
      p_q_q          <= '0;
      s1_valid_q     <= 1'b0;
      s1_first_q     <= 1'b0;
      s1_last_q      <= 1'b0;
      acc_i_q        <= '0;
      acc_q_q        <= '0;
      i_corr_q       <= '0;
      q_corr_q       <= '0;
      symbol_out_q   <= 2'b00;
      symbol_valid_q <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      p_i_q          <= p_i_d;
      p_q_q          <= p_q_d;
      s1_valid_q     <= s1_valid_d;
      s1_first_q     <= s1_first_d;
      s1_last_q      <= s1_last_d;
      acc_i_q        <= acc_i_d;
      acc_q_q        <= acc_q_d;
      i_corr_q       <= i_corr_d;
      q_corr_q       <= q_corr_d;
      symbol_out_q   <= symbol_out_d;
      symbol_valid_q <= symbol_valid_d;
    end
  end

  assign i_corr       = i_corr_q;
  assign q_corr       = q_corr_q;
  assign symbol_out   = symbol_out_q;
  assign symbol_valid = symbol_valid_q;

`ifdef QPSK_DET_ERASE_EN
  logic signed [21:0] abs_i, abs_q;
  logic               erasure_q, erasure_d;

  // Erasure when either rail is too weak to trust the decision.
  always_comb begin
    abs_i     = acc_i_d[21] ? -acc_i_d : acc_i_d;
    abs_q     = acc_q_d[21] ? -acc_q_d : acc_q_d;
    erasure_d = erasure_q;
    if (symbol_valid_d)
      erasure_d = (abs_i < 22'(ERASE_THRESH)) || (abs_q < 22'(ERASE_THRESH));
  end

  // Erasure flag register, updated with each completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) erasure_q <= 1'b0;
    else        erasure_q <= erasure_d;
  end

  assign erasure = erasure_q;
`endif

endmodule
